// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD counters.
// No logic, so no latency or backpressure; the blink helper is used only under STOPWATCH_BLINK_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJ    = 2'd2
  } state_e;

  typedef enum logic {
    FIELD_SEC = 1'b0,
    FIELD_MIN = 1'b1
  } field_e;

  localparam int BCD_W       = 4;
  localparam int DEF_MIN_MOD = 60;
  localparam int DEF_SEC_MOD = 60;

  // Blank bits for a field, ordered {minTens, minOnes, secTens, secOnes}.
  function automatic logic [3:0] field_blank(field_e f);
    return (f == FIELD_MIN) ? 4'b1100 : 4'b0011;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps at MOD-1 -> 00; clr overrides inc.
// Digits update one clk after inc/clr; carry is combinational (inc at MOD-1) and there is no backpressure.
module bcd2_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD = DEF_SEC_MOD
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             clr,
  input  logic             inc,
  output logic             carry,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'((MOD - 1) / 10);
  localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'((MOD - 1) % 10);
  localparam logic [BCD_W-1:0] NINE     = BCD_W'(9);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;
  logic             at_max;

  assign at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
  assign carry  = inc && !clr && at_max;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc) begin
      if (at_max) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == NINE) begin
        tens_d = tens_q + BCD_W'(1);
        ones_d = '0;
      end else begin
        ones_d = ones_q + BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust controller for the mm:ss BCD stopwatch; field blinking only with STOPWATCH_BLINK_EN.
// All outputs registered, one clk after the qualifying pulse/tick; no backpressure.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MIN_MOD = DEF_MIN_MOD,
  parameter int SEC_MOD = DEF_SEC_MOD
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             tick1Hz,
  input  logic             tick2Hz,
  input  logic             rstP,
  input  logic             pauseP,
  input  logic             selP,
  input  logic             adjP,
  output logic [BCD_W-1:0] minTens,
  output logic [BCD_W-1:0] minOnes,
  output logic [BCD_W-1:0] secTens,
  output logic [BCD_W-1:0] secOnes,
  output logic             running,
  output logic             adjMode,
  output logic             selField,
  output logic [3:0]       blankMask
);

  state_e state_q, state_d;
  field_e sel_q, sel_d;
  logic   running_q, adj_q;
  logic   adj_tick;
  logic   sec_inc, min_inc, sec_carry, min_carry_unused;

  // Ticks act in the pre-transition state; a coincident rstP swallows them.
  assign adj_tick = !rstP && (state_q == ADJ) && tick2Hz;
  assign sec_inc  = !rstP && (((state_q == RUN) && tick1Hz) ||
                              (adj_tick && (sel_q == FIELD_SEC)));
  assign min_inc  = !rstP && (((state_q == RUN) && sec_carry) ||
                              (adj_tick && (sel_q == FIELD_MIN)));

  // pauseP is a no-op in ADJ, so a coincident selP still toggles the field.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (rstP) begin
      state_d = PAUSED;
      sel_d   = FIELD_SEC;
    end else if (adjP) begin
      state_d = (state_q == ADJ) ? PAUSED : ADJ;
    end else if (pauseP && (state_q != ADJ)) begin
      state_d = (state_q == RUN) ? PAUSED : RUN;
    end else if (selP && (state_q == ADJ)) begin
      sel_d = (sel_q == FIELD_SEC) ? FIELD_MIN : FIELD_SEC;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= PAUSED;
      sel_q     <= FIELD_SEC;
      running_q <= 1'b0;
      adj_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      running_q <= (state_d == RUN);
      adj_q     <= (state_d == ADJ);
    end
  end

  bcd2_counter #(.MOD(SEC_MOD)) u_sec (
    .clk   (clk),
    .rstN  (rstN),
    .clr   (rstP),
    .inc   (sec_inc),
    .carry (sec_carry),
    .tens  (secTens),
    .ones  (secOnes)
  );

  // Minutes wrap silently; their carry has no consumer.
  bcd2_counter #(.MOD(MIN_MOD)) u_min (
    .clk   (clk),
    .rstN  (rstN),
    .clr   (rstP),
    .inc   (min_inc),
    .carry (min_carry_unused),
    .tens  (minTens),
    .ones  (minOnes)
  );

`ifdef STOPWATCH_BLINK_EN
  logic       blink_q, blink_d;
  logic [3:0] blank_q, blank_d;

  always_comb begin
    blink_d = blink_q;
    if (rstP || (adjP && (state_q != ADJ))) begin
      blink_d = 1'b0;
    end else if (adj_tick) begin
      blink_d = !blink_q;
    end
    blank_d = ((state_d == ADJ) && blink_d) ? field_blank(sel_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      blink_q <= 1'b0;
      blank_q <= 4'b0000;
    end else begin
      blink_q <= blink_d;
      blank_q <= blank_d;
    end
  end

  assign blankMask = blank_q;
`else
  assign blankMask = 4'b0000;
`endif

  assign running  = running_q;
  assign adjMode  = adj_q;
  assign selField = (sel_q == FIELD_MIN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random pulses against an mm:ss arithmetic model.
// Model and DUT both advance on posedge; all outputs are compared on every negedge.
module tb_stopwatch_ctrl;

  localparam int MIN_MOD = 60;
  localparam int SEC_MOD = 60;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       tick1Hz = 1'b0, tick2Hz = 1'b0;
  logic       rstP = 1'b0, pauseP = 1'b0, selP = 1'b0, adjP = 1'b0;
  logic [3:0] minTens, minOnes, secTens, secOnes;
  logic       running, adjMode, selField;
  logic [3:0] blankMask;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: plain minute/second integers and a mode number (0 paused, 1 run, 2 adjust).
  int m_min, m_sec, m_mode, m_sel, m_blink;

  stopwatch_ctrl #(.MIN_MOD(MIN_MOD), .SEC_MOD(SEC_MOD)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .tick1Hz   (tick1Hz),
    .tick2Hz   (tick2Hz),
    .rstP      (rstP),
    .pauseP    (pauseP),
    .selP      (selP),
    .adjP      (adjP),
    .minTens   (minTens),
    .minOnes   (minOnes),
    .secTens   (secTens),
    .secOnes   (secOnes),
    .running   (running),
    .adjMode   (adjMode),
    .selField  (selField),
    .blankMask (blankMask)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_min = 0; m_sec = 0; m_mode = 0; m_sel = 0; m_blink = 0;
    end else if (rstP) begin
      m_min = 0; m_sec = 0; m_mode = 0; m_sel = 0; m_blink = 0;
    end else begin
      if (m_mode == 1 && tick1Hz) begin
        m_sec = m_sec + 1;
        if (m_sec == SEC_MOD) begin
          m_sec = 0;
          m_min = (m_min + 1) % MIN_MOD;
        end
      end
      if (m_mode == 2 && tick2Hz) begin
        if (m_sel == 1) m_min = (m_min + 1) % MIN_MOD;
        else            m_sec = (m_sec + 1) % SEC_MOD;
        m_blink = 1 - m_blink;
      end
      if (adjP) begin
        if (m_mode == 2) m_mode = 0;
        else begin
          m_mode  = 2;
          m_blink = 0;
        end
      end else if (pauseP && m_mode != 2) begin
        m_mode = (m_mode == 1) ? 0 : 1;
      end else if (selP && m_mode == 2) begin
        m_sel = 1 - m_sel;
      end
    end
  end

  function automatic logic [15:0] exp_digits();
    logic [3:0] mt, mo, st, so;
    mt = 4'(m_min / 10); mo = 4'(m_min % 10);
    st = 4'(m_sec / 10); so = 4'(m_sec % 10);
    return {mt, mo, st, so};
  endfunction

  function automatic logic [3:0] exp_mask();
`ifdef STOPWATCH_BLINK_EN
    if (m_mode == 2 && m_blink == 1) return (m_sel == 1) ? 4'b1100 : 4'b0011;
`endif
    return 4'b0000;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("digits",    {minTens, minOnes, secTens, secOnes}, exp_digits());
      check("running",   16'(running),  16'(m_mode == 1));
      check("adjMode",   16'(adjMode),  16'(m_mode == 2));
      check("selField",  16'(selField), 16'(m_sel));
      check("blankMask", 16'(blankMask), 16'(exp_mask()));
    end
  end

  // One clock cycle with the given pulses, inputs cleared just after the edge.
  task automatic cyc(input logic t1, input logic t2, input logic r,
                     input logic p, input logic s, input logic a);
    tick1Hz = t1; tick2Hz = t2; rstP = r; pauseP = p; selP = s; adjP = a;
    @(posedge clk);
    #1;
    tick1Hz = 0; tick2Hz = 0; rstP = 0; pauseP = 0; selP = 0; adjP = 0;
  endtask

  task automatic ticks1(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks2(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0);
  endtask

  function automatic logic [15:0] disp();
    return {minTens, minOnes, secTens, secOnes};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    chk_en = 1'b1;
    #1;
    check("reset_digits", disp(), 16'h0000);
    check("reset_mask",   16'(blankMask), 16'h0);
    check("reset_run",    16'(running),   16'h0);

    // 1: 61 seconds of counting
    cyc(0, 0, 0, 1, 0, 0);
    ticks1(61);
    check("t1_digits",  disp(), 16'h0101);
    check("t1_running", 16'(running), 16'h1);

    // 2: preload 59:58, then roll over to 00:00
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    ticks2(59);
    cyc(0, 0, 0, 0, 1, 0);
    ticks2(58);
    check("t2_preload", disp(), 16'h5958);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    ticks1(1);
    check("t2_5959", disp(), 16'h5959);
    ticks1(1);
    check("t2_wrap", disp(), 16'h0000);

    // 3: tick coinciding with pause still counts
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    ticks1(5);
    check("t3_0005", disp(), 16'h0005);
    cyc(1, 0, 0, 1, 0, 0);
    check("t3_0006",  disp(), 16'h0006);
    check("t3_paused", 16'(running), 16'h0);
    ticks1(3);
    check("t3_hold", disp(), 16'h0006);

    // 4: adjust minutes by three, watch the blink mask
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      ticks2(1);
`ifdef STOPWATCH_BLINK_EN
      check("t4_blink", 16'(blankMask), (i % 2 == 0) ? 16'hC : 16'h0);
`else
      check("t4_blink", 16'(blankMask), 16'h0);
`endif
    end
    check("t4_digits", disp(), 16'h0300);
    check("t4_adj",    16'(adjMode),  16'h1);
    check("t4_sel",    16'(selField), 16'h1);

    // 5: rstP beats adjP mid-adjust
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    ticks2(12);
    cyc(0, 0, 0, 0, 1, 0);
    ticks2(34);
    check("t5_1234", disp(), 16'h1234);
    cyc(0, 1, 1, 0, 0, 1);
    check("t5_digits", disp(), 16'h0000);
    check("t5_adj",    16'(adjMode),   16'h0);
    check("t5_run",    16'(running),   16'h0);
    check("t5_sel",    16'(selField),  16'h0);
    check("t5_mask",   16'(blankMask), 16'h0);

    // 6: async reset mid-count at 07:42
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    ticks2(7);
    cyc(0, 0, 0, 0, 1, 0);
    ticks2(42);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    check("t6_0742", disp(), 16'h0742);
    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    check("t6_async_digits", disp(), 16'h0000);
    check("t6_async_run",    16'(running), 16'h0);
    @(negedge clk);
    rstN = 1'b1;
    ticks1(3);
    check("t6_no_run", disp(), 16'h0000);
    cyc(0, 0, 0, 1, 0, 0);
    ticks1(1);
    check("t6_resume", disp(), 16'h0001);

    // Random pulses and ticks against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 99) == 0),
          1'($urandom_range(0, 24) == 0),
          1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 19) == 0));
    end
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequences the stopwatch minutes/seconds datapath from the single-cycle button pulses produced by the input debouncer (rst, pause, sel, adj).
- Owns the run/pause/adjust state machine and the two-digit BCD minute and second counters.
- Produces the digits and a per-digit blank mask for the seven-segment display driver.
- Advances on externally generated clock-enable ticks (1 Hz count, 2 Hz adjust/blink); it never divides the clock itself.

Parameters:
- MIN_MOD, 60: minute counter modulus. Legal range 2..100; 100 wraps 99->00.
- SEC_MOD, 60: second counter modulus. Legal range 2..100.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstN  in  1  asynchronous active-low reset.
- tick1Hz  in  1  single-cycle count enable.
- tick2Hz  in  1  single-cycle adjust/blink enable.
- rstP  in  1  debounced soft-clear pulse.
- pauseP  in  1  debounced pause-toggle pulse.
- selP  in  1  debounced field-select toggle pulse.
- adjP  in  1  debounced adjust-mode toggle pulse.
- minTens  out  4  BCD minutes tens.
- minOnes  out  4  BCD minutes ones.
- secTens  out  4  BCD seconds tens.
- secOnes  out  4  BCD seconds ones.
- running  out  1  high in RUN.
- adjMode  out  1  high in ADJ.
- selField  out  1  0 = seconds, 1 = minutes.
- blankMask  out  4  {minTens, minOnes, secTens, secOnes}; 1 = blank that digit.

Behaviour:
- rstN low, asynchronously: state = PAUSED, all digits = 0, selField = 0, blink phase = 0, running = 0, adjMode = 0, blankMask = 0000.
- All outputs registered. Each takes effect one clk after the qualifying input cycle.
- States and transitions:
  - PAUSED: pauseP -> RUN; adjP -> ADJ.
  - RUN: tick1Hz increments seconds. pauseP -> PAUSED; adjP -> ADJ.
  - ADJ: pauseP ignored; adjP -> PAUSED; selP toggles selField; tick2Hz increments the selected field only (no carry) and toggles blink phase.
- Priority within one cycle: rstP > adjP > pauseP > selP.
  - rstP clears digits to 00:00 and selField to 0, and forces PAUSED. This holds from any state, including ADJ mid-adjust.
  - selP outside ADJ is ignored.
- Count arithmetic in RUN:
  - secOnes 9->0 carries to secTens.
  - Seconds at SEC_MOD-1 -> 00, with carry to minutes.
  - Minutes at MIN_MOD-1 -> 00, no carry out; 59:59 -> 00:00.
- A tick coinciding with a state-changing pulse is evaluated in the old state. Example: tick1Hz with pauseP while in RUN still increments.
- A tick coinciding with rstP is discarded.
- In ADJ, increment wraps at the field modulus: 59 -> 00 for the default modulus.
- Blink phase resets to 0 on entering ADJ.
- Digits are always valid BCD (nibbles 0..9); there are no illegal intermediate values.

Optional Feature:
- STOPWATCH_BLINK_EN.
- Defined: in ADJ with blink phase = 1, blankMask has the selected field's two bits set (1100 minutes, 0011 seconds); otherwise 0000.
- Undefined: blankMask is tied to 0000 and no blink-phase flop is built.
- All other behaviour is identical in both builds.

Decomposition:
- Package stopwatch_pkg holds:
  - state enum {PAUSED, RUN, ADJ};
  - field enum {FIELD_SEC, FIELD_MIN};
  - constant BCD_W = 4;
  - default moduli.
- Sub-module bcd2_counter:
  - two-digit BCD counter with parameter MOD;
  - ports: clk, rstN, clr, inc, carry;
  - instantiated twice (seconds, minutes).
- The controller FSM and blink logic stay in stopwatch_ctrl.

Test Plan:
1. Reset, pauseP, then 61 tick1Hz pulses -> running = 1, display 01:01.
2. Preload 59:58 via ADJ, adjP, pauseP, then 2 tick1Hz -> 59:59 then 00:00, no glitch digits.
3. In RUN at 00:05, pauseP and tick1Hz in the same cycle -> 00:06 and PAUSED. A further 3 tick1Hz -> still 00:06.
4. adjP, selP, then 3 tick2Hz -> adjMode = 1, selField = 1, minutes 00 -> 03, seconds unchanged. With STOPWATCH_BLINK_EN, blankMask alternates 1100 / 0000.
5. In ADJ at 12:34, rstP and adjP in the same cycle -> 00:00, PAUSED, selField = 0, blankMask = 0000.
6. Assert rstN low mid-count at 07:42 between clk edges -> outputs clear immediately; after release, counting resumes only after a fresh pauseP.
